i2c_temp_responder: RTL and testbench

- I2C target (slave) model of the temperature sensor. It answers the I2C read/write transactions issued by the temperature-sensor master FSM.
- Used in simulation benches as the far end of the bus, and in hardware loopback with the master.
- Oversamples SCL/SDA on the system clock, decodes START/STOP/address/pointer/data, and drives SDA open-drain from a small register map.

---
 rtl/i2c_pkg.sv | 34 +++
 rtl/i2c_line_sync.sv | 47 ++++
 rtl/i2c_temp_responder.sv | 169 ++++++++++++++++
 tb/tb_i2c_temp_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C temperature-sensor target: FSM states,
// register addresses and the read-side register map.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      TX_BYTE,
      RX_ACK,
      IGNORE
   } state_t;

   localparam logic [7:0] REG_TEMP_MSB = 8'h00;
   localparam logic [7:0] REG_TEMP_LSB = 8'h01;
   localparam logic [7:0] REG_ID       = 8'h0B;

   function automatic logic [7:0] read_reg(input logic [7:0]  ptr,
                                           input logic [15:0] word,
                                           input logic [7:0]  id);
      logic [7:0] v;
      case (ptr)
         REG_TEMP_MSB: v = word[15:8];
         REG_TEMP_LSB: v = word[7:0];
         REG_ID:       v = id;
         default:      v = 8'h00;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers plus edge and START/STOP detection on the
// synchronized lines.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic sda_s,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_sh;
   logic [SYNC_STAGES-1:0] sda_sh;
   logic                   scl_prev;
   logic                   sda_prev;
   logic                   scl_s;

   always_ff @(posedge clk) begin
      if (reset) begin
         scl_sh   <= '1;
         sda_sh   <= '1;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_sh   <= {scl_sh[SYNC_STAGES-2:0], scl_in};
         sda_sh   <= {sda_sh[SYNC_STAGES-2:0], sda_in};
         scl_prev <= scl_s;
         sda_prev <= sda_s;
      end
   end

   assign scl_s    = scl_sh[SYNC_STAGES-1];
   assign sda_s    = sda_sh[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_prev;
   assign scl_fall = ~scl_s & scl_prev;

   // SCL must be high on both samples, so an SDA edge that coincides with
   // an SCL edge is treated as ambiguous and dropped.
   assign start_det = sda_prev & ~sda_s & scl_s & scl_prev;
   assign stop_det  = ~sda_prev & sda_s & scl_s & scl_prev;

endmodule

// File: rtl/i2c_temp_responder.sv
// I2C target modelling the temperature sensor: pointer write, register reads
// with auto-increment, open-drain SDA drive.
module i2c_temp_responder
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = 7'h4B,
   parameter logic [7:0] ID_VALUE    = 8'hCB,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   input  logic [15:0] temp_data,
   output logic [7:0]  reg_ptr,
   output logic        busy,
   output logic        addr_hit
);

   logic scl_rise, scl_fall, sda_s, start_det, stop_det;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
      .clk       (clk),
      .reset     (reset),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .sda_s     (sda_s),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   state_t      state, state_n;
   logic [3:0]  bit_cnt, bit_cnt_n;
   logic [7:0]  sh, sh_n;
   logic [7:0]  tx, tx_n;
   logic [15:0] shadow, shadow_n;
   logic        rw, rw_n;
   logic [7:0]  ptr_n;
   logic        oe_n, busy_n, hit_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         bit_cnt  <= 4'd0;
         sh       <= 8'h00;
         tx       <= 8'h00;
         shadow   <= 16'h0000;
         rw       <= 1'b0;
         reg_ptr  <= 8'h00;
         sda_oe   <= 1'b0;
         busy     <= 1'b0;
         addr_hit <= 1'b0;
      end else begin
         state    <= state_n;
         bit_cnt  <= bit_cnt_n;
         sh       <= sh_n;
         tx       <= tx_n;
         shadow   <= shadow_n;
         rw       <= rw_n;
         reg_ptr  <= ptr_n;
         sda_oe   <= oe_n;
         busy     <= busy_n;
         addr_hit <= hit_n;
      end
   end

   // sda_oe only changes on scl_fall (or on bus conditions, which release it),
   // so the target never moves SDA while SCL is high.
   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      sh_n      = sh;
      tx_n      = tx;
      shadow_n  = shadow;
      rw_n      = rw;
      ptr_n     = reg_ptr;
      oe_n      = sda_oe;
      busy_n    = busy;
      hit_n     = 1'b0;
      if (stop_det) begin
         state_n = IDLE;
         oe_n    = 1'b0;
         busy_n  = 1'b0;
      end else if (start_det) begin
         state_n   = ADDR;
         bit_cnt_n = 4'd0;
         oe_n      = 1'b0;
      end else begin
         case (state)
            IDLE: ;
            ADDR, PTR, WDATA: begin
               if (scl_rise) begin
                  sh_n      = {sh[6:0], sda_s};
                  bit_cnt_n = bit_cnt + 4'd1;
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  bit_cnt_n = 4'd0;
                  if (state == ADDR) begin
                     if (sh[7:1] == DEV_ADDR) begin
                        hit_n   = 1'b1;
                        busy_n  = 1'b1;
                        rw_n    = sh[0];
                        oe_n    = 1'b1;
                        state_n = ADDR_ACK;
                     end else begin
                        state_n = IGNORE;
                     end
                  end else begin
                     if (state == PTR) ptr_n = sh;
                     oe_n    = 1'b1;
                     state_n = PTR_ACK;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  bit_cnt_n = 4'd0;
                  if (rw) begin
                     shadow_n = temp_data;
                     tx_n     = read_reg(reg_ptr, temp_data, ID_VALUE);
                     oe_n     = ~tx_n[7];
                     state_n  = TX_BYTE;
                  end else begin
                     oe_n    = 1'b0;
                     state_n = PTR;
                  end
               end
            end
            PTR_ACK: begin
               if (scl_fall) begin
                  oe_n      = 1'b0;
                  bit_cnt_n = 4'd0;
                  state_n   = WDATA;
               end
            end
            TX_BYTE: begin
               // bit_cnt counts rises; the fall after rise n drives bit 7-n.
               if (scl_rise) begin
                  bit_cnt_n = bit_cnt + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     oe_n    = 1'b0;
                     state_n = RX_ACK;
                  end else begin
                     oe_n = ~tx[~bit_cnt[2:0]];
                  end
               end
            end
            RX_ACK: begin
               if (scl_rise) begin
                  if (!sda_s) begin
                     ptr_n     = reg_ptr + 8'd1;
                     tx_n      = read_reg(ptr_n, shadow, ID_VALUE);
                     bit_cnt_n = 4'd0;
                     state_n   = TX_BYTE;
                  end else begin
                     state_n = IGNORE;
                  end
               end
            end
            IGNORE: oe_n = 1'b0;
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_temp_responder.sv
// Directed bench: a bit-level I2C master drives the responder; observed
// bytes, ACKs and status flow through an expected/actual scoreboard.
module tb_i2c_temp_responder;
   import i2c_pkg::*;

   localparam int Q = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        scl_m, sda_m;
   logic        sda_oe;
   logic [15:0] temp_data;
   logic [7:0]  reg_ptr;
   logic        busy, addr_hit;
   logic        sda_bus;

   assign sda_bus = sda_m & ~sda_oe;

   i2c_temp_responder dut (
      .clk       (clk),
      .reset     (reset),
      .scl_in    (scl_m),
      .sda_in    (sda_bus),
      .sda_oe    (sda_oe),
      .temp_data (temp_data),
      .reg_ptr   (reg_ptr),
      .busy      (busy),
      .addr_hit  (addr_hit)
   );

   always #5 clk = ~clk;

   // scoreboard
   logic [7:0] exp_q[$];
   logic [7:0] act_q[$];
   string      name_q[$];
   int         vectors = 0;
   int         miscompares = 0;
   int         hit_cnt = 0;

   always @(negedge clk) if (addr_hit) hit_cnt++;

   task automatic check(input string n, input logic [7:0] act, input logic [7:0] exp);
      exp_q.push_back(exp);
      name_q.push_back(n);
      act_q.push_back(act);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         while (act_q.size() > 0) begin
            logic [7:0] a, e;
            string n;
            a = act_q.pop_front();
            e = exp_q.pop_front();
            n = name_q.pop_front();
            vectors++;
            if (a !== e) begin
               miscompares++;
               $display("FAIL %s: got %h, expected %h", n, a, e);
            end
         end
      end
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b1; tick(Q);
   endtask

   task automatic bit_io(input logic b, output logic r);
      sda_m = b;    tick(Q);
      scl_m = 1'b1; tick(Q);
      r = sda_bus;  tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_io(b[i], r);
      bit_io(1'b1, ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] v);
      logic r;
      v = 8'h00;
      for (int i = 0; i < 8; i++) begin
         bit_io(1'b1, r);
         v = {v[6:0], r};
      end
      bit_io(mack, r);
   endtask

   initial begin
      logic       ack, r;
      logic [7:0] v;
      int         h0;

      reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; temp_data = 16'h0000;
      tick(5);
      reset = 1'b0;
      tick(1000);
      check("idle_sda_oe", {7'b0, sda_oe}, 8'h00);
      check("idle_busy", {7'b0, busy}, 8'h00);
      check("idle_reg_ptr", reg_ptr, 8'h00);

      // pointer write 0x00
      h0 = hit_cnt;
      i2c_start();
      write_byte(8'h96, ack);
      check("wr_addr_ack", {7'b0, ack}, 8'h00);
      check("wr_addr_hit_pulses", 8'(hit_cnt - h0), 8'h01);
      check("wr_busy", {7'b0, busy}, 8'h01);
      write_byte(8'h00, ack);
      check("wr_ptr_ack", {7'b0, ack}, 8'h00);
      i2c_stop();
      tick(10);
      check("wr_reg_ptr", reg_ptr, 8'h00);
      check("wr_busy_after_stop", {7'b0, busy}, 8'h00);

      // two-byte read with mid-read temp change
      temp_data = 16'h0C80;
      i2c_start();
      write_byte(8'h97, ack);
      check("rd_addr_ack", {7'b0, ack}, 8'h00);
      read_byte(1'b0, v);
      check("rd_msb", v, 8'h0C);
      check("rd_ptr_after_ack", reg_ptr, 8'h01);
      temp_data = 16'h1234;
      read_byte(1'b1, v);
      check("rd_lsb_coherent", v, 8'h80);
      i2c_stop();
      tick(10);
      check("rd_busy_after_stop", {7'b0, busy}, 8'h00);

      // pointer 0x0B, extra write byte discarded, repeated START, ID read
      i2c_start();
      write_byte(8'h96, ack);
      write_byte(8'h0B, ack);
      check("id_ptr_ack", {7'b0, ack}, 8'h00);
      write_byte(8'h55, ack);
      check("wdata_ack", {7'b0, ack}, 8'h00);
      check("wdata_ptr_unchanged", reg_ptr, 8'h0B);
      i2c_start();
      write_byte(8'h97, ack);
      check("id_addr_ack", {7'b0, ack}, 8'h00);
      read_byte(1'b1, v);
      check("id_value", v, 8'hCB);
      tick(4);
      check("id_state_ignore", 8'(dut.state), 8'(IGNORE));
      bit_io(1'b1, r);
      check("id_ignore_sda_released", {7'b0, r}, 8'h01);
      check("id_ignore_sda_oe", {7'b0, sda_oe}, 8'h00);
      i2c_stop();
      tick(10);
      check("id_state_idle", 8'(dut.state), 8'(IDLE));
      check("id_busy_after_stop", {7'b0, busy}, 8'h00);

      // wrong address
      h0 = hit_cnt;
      i2c_start();
      write_byte(8'h90, ack);
      check("miss_nack", {7'b0, ack}, 8'h01);
      check("miss_addr_hit", 8'(hit_cnt - h0), 8'h00);
      check("miss_busy", {7'b0, busy}, 8'h00);
      i2c_stop();
      tick(10);

      // pointer wrap, reset mid-byte
      temp_data = 16'h0C80;
      i2c_start();
      write_byte(8'h96, ack);
      write_byte(8'hFF, ack);
      check("wrap_ptr", reg_ptr, 8'hFF);
      i2c_start();
      write_byte(8'h97, ack);
      read_byte(1'b0, v);
      check("wrap_first", v, 8'h00);
      check("wrap_ptr_zero", reg_ptr, 8'h00);
      for (int i = 0; i < 3; i++) bit_io(1'b1, r);
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      check("wrap_bit3_driven", {7'b0, sda_oe}, 8'h01);
      reset = 1'b1;
      tick(1);
      check("rst_sda_oe", {7'b0, sda_oe}, 8'h00);
      check("rst_state", 8'(dut.state), 8'(IDLE));
      tick(3);
      reset = 1'b0;
      tick(20);
      check("rst_busy", {7'b0, busy}, 8'h00);
      check("rst_reg_ptr", reg_ptr, 8'h00);

      for (int i = 0; i < 100 && act_q.size() > 0; i++) tick(1);
      if (act_q.size() > 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", act_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
